// File: rtl/uart16550_ahb_driver.sv
// AHB-Lite master that programs a 16550 UART after reset, then polls LSR and bridges
// received/transmitted bytes to valid/ready byte streams.
module uart16550_ahb_driver #(
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
    parameter logic [15:0] DIVISOR   = 16'd27,
    parameter logic [7:0]  LCR_VAL   = 8'h03,
    parameter logic [7:0]  FCR_VAL   = 8'hC7,
    parameter int unsigned POLL_GAP  = 4
) (
    input  logic        HCLK,
    input  logic        HRESETn,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    input  logic [7:0]  tx_data,
    input  logic        tx_valid,
    output logic        tx_ready,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    input  logic        rx_ready,
    output logic        init_done,
    output logic        rx_err
);

    typedef enum logic [3:0] {
        StInitA, StInitD, StGap, StPollA, StPollD, StDecide, StRdA, StRdD, StWrA, StWrD
    } state_e;

    localparam logic [1:0] HtransIdle   = 2'b00;
    localparam logic [1:0] HtransNonseq = 2'b10;
    localparam logic [7:0] GapLast      = (POLL_GAP == 0) ? 8'd0 : 8'(POLL_GAP - 1);

    // Init table entry: {register index, byte}.
    function automatic logic [10:0] init_word(input logic [2:0] step);
        case (step)
            3'd0:    return {3'd3, LCR_VAL | 8'h80};
            3'd1:    return {3'd0, DIVISOR[7:0]};
            3'd2:    return {3'd1, DIVISOR[15:8]};
            3'd3:    return {3'd3, LCR_VAL & 8'h7F};
            3'd4:    return {3'd2, FCR_VAL};
            default: return {3'd1, 8'h00};
        endcase
    endfunction

    state_e      state_q, state_d;
    logic [2:0]  step_q, step_d;
    logic [7:0]  gap_cnt_q, gap_cnt_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic [7:0]  lsr_q, lsr_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        rx_valid_q, rx_valid_d;
    logic        init_done_q, init_done_d;
    logic        rx_err_q, rx_err_d;

    logic        launch, go_gap, start_poll, take_rx, take_tx, l_wr;
    logic [2:0]  l_idx;
    logic [7:0]  l_byte;
    logic [10:0] next_init;
    logic        unused_in;

    assign unused_in = ^{HRESP, HRDATA[31:8]};

    assign take_rx = lsr_q[0] && !rx_valid_q;
    assign take_tx = !take_rx && lsr_q[5] && tx_valid;

    always_comb begin
        state_d     = state_q;
        step_d      = step_q;
        gap_cnt_d   = gap_cnt_q;
        htrans_d    = htrans_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hwdata_d    = hwdata_q;
        lsr_d       = lsr_q;
        rx_data_d   = rx_data_q;
        rx_valid_d  = rx_valid_q;
        init_done_d = init_done_q;
        rx_err_d    = rx_err_q;
        launch      = 1'b0;
        go_gap      = 1'b0;
        start_poll  = 1'b0;
        l_idx       = 3'd0;
        l_wr        = 1'b0;
        l_byte      = 8'h00;
        next_init   = init_word(step_q + 3'd1);

        if (rx_valid_q && rx_ready) rx_valid_d = 1'b0;

        unique case (state_q)
            StInitA: begin
                // Right after reset the bus is idle, so the first init write is launched here.
                if (htrans_q == HtransIdle) begin
                    launch = 1'b1;
                    l_wr   = 1'b1;
                    {l_idx, l_byte} = init_word(step_q);
                end else if (HREADY) begin
                    htrans_d = HtransIdle;
                    state_d  = StInitD;
                end
            end
            StInitD: if (HREADY) begin
                if (step_q == 3'd5) begin
                    init_done_d = 1'b1;
                    go_gap      = 1'b1;
                end else begin
                    step_d  = step_q + 3'd1;
                    state_d = StInitA;
                    launch  = 1'b1;
                    l_wr    = 1'b1;
                    {l_idx, l_byte} = next_init;
                end
            end
            StGap: begin
                if (gap_cnt_q == GapLast) start_poll = 1'b1;
                else gap_cnt_d = gap_cnt_q + 8'd1;
            end
            StPollA: if (HREADY) begin
                htrans_d = HtransIdle;
                state_d  = StPollD;
            end
            StPollD: if (HREADY) begin
                lsr_d    = HRDATA[7:0];
                rx_err_d = rx_err_q | (|HRDATA[3:1]);
                state_d  = StDecide;
            end
            StDecide: begin
                if (take_rx) begin
                    launch  = 1'b1;
                    state_d = StRdA;
                end else if (take_tx) begin
                    launch  = 1'b1;
                    l_wr    = 1'b1;
                    l_byte  = tx_data;
                    state_d = StWrA;
                end else begin
                    go_gap = 1'b1;
                end
            end
            StRdA: if (HREADY) begin
                htrans_d = HtransIdle;
                state_d  = StRdD;
            end
            StRdD: if (HREADY) begin
                rx_data_d  = HRDATA[7:0];
                rx_valid_d = 1'b1;
                go_gap     = 1'b1;
            end
            StWrA: if (HREADY) begin
                htrans_d = HtransIdle;
                state_d  = StWrD;
            end
            StWrD: if (HREADY) go_gap = 1'b1;
            default: state_d = StInitA;
        endcase

        if (go_gap) begin
            gap_cnt_d = 8'd0;
            if (POLL_GAP == 0) start_poll = 1'b1;
            else state_d = StGap;
        end
        if (start_poll) begin
            launch  = 1'b1;
            l_idx   = 3'd5;
            l_wr    = 1'b0;
            state_d = StPollA;
        end
        if (launch) begin
            htrans_d = HtransNonseq;
            haddr_d  = BASE_ADDR + {27'b0, l_idx, 2'b00};
            hwrite_d = l_wr;
            hwdata_d = {24'b0, l_byte};
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q     <= StInitA;
            step_q      <= 3'd0;
            gap_cnt_q   <= 8'd0;
            htrans_q    <= HtransIdle;
            haddr_q     <= BASE_ADDR;
            hwrite_q    <= 1'b0;
            hwdata_q    <= 32'h0;
            lsr_q       <= 8'h00;
            rx_data_q   <= 8'h00;
            rx_valid_q  <= 1'b0;
            init_done_q <= 1'b0;
            rx_err_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            step_q      <= step_d;
            gap_cnt_q   <= gap_cnt_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hwdata_q    <= hwdata_d;
            lsr_q       <= lsr_d;
            rx_data_q   <= rx_data_d;
            rx_valid_q  <= rx_valid_d;
            init_done_q <= init_done_d;
            rx_err_q    <= rx_err_d;
        end
    end

    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = 3'b010;
    assign HBURST    = 3'b000;
    assign HWDATA    = hwdata_q;
    assign tx_ready  = (state_q == StDecide) && take_tx;
    assign rx_data   = rx_data_q;
    assign rx_valid  = rx_valid_q;
    assign init_done = init_done_q;
    assign rx_err    = rx_err_q;

endmodule
